// File: rtl/sync_fifo_circ.sv
// -----------------------------------------------------------------------------
// sync_fifo_circ
//
// Single-clock circular-buffer FIFO. Storage stays in place; read and write
// pointers walk around it and wrap by natural binary overflow. A read and a
// write can both be accepted in the same cycle at any occupancy, including
// full (the read frees the slot that the write fills) and empty (only the
// write is accepted there).
//
// Compile-time option:
//   FIFO_FWFT_EN  defined   -> first-word-fall-through. o_data shows the head
//                              entry combinationally, o_valid = !empty, and
//                              rden acknowledges/pops the head.
//                 undefined -> registered read. o_data loads the head on an
//                              accepted read, o_valid pulses the next cycle.
//
// Handshake: a write is taken on a rising edge when wren=1 and the FIFO is
// not full, or when it is full and a read is accepted on the same edge.
// A read is taken when rden=1 and the FIFO is not empty. Requests that are
// not taken leave pointers, count and storage untouched and set the sticky
// overflow/underflow flags instead.
//
// Ports:
//   clk           clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   wren          write request
//   i_data        write data, sampled when the write is accepted
//   rden          read request / pop
//   o_data        read data
//   o_valid       o_data holds a popped (or head) entry
//   full, empty   count == DEPTH / count == 0
//   almost_full   count >= AFULL_THRESH
//   almost_empty  count <= AEMPTY_THRESH
//   count         occupancy 0..DEPTH
//   overflow      sticky: write requested and rejected
//   underflow     sticky: read requested on empty
//   clr_err       synchronous clear of overflow/underflow (a new set wins)
// -----------------------------------------------------------------------------
module sync_fifo_circ #(
    parameter int DEPTH         = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wren,
    input  logic [DATA_WIDTH-1:0]      i_data,
    input  logic                       rden,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic                       o_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] LP_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] LP_AFULL  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] LP_AEMPTY = CW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;

    // Status flags decode the registered count only, so they move one cycle
    // after the accepting edge.
    assign w_full   = (r_count == LP_DEPTH);
    assign w_empty  = (r_count == '0);

    assign w_rd_acc = rden & ~w_empty;
    // At full a write still fits if the same edge also pops an entry.
    assign w_wr_acc = wren & (~w_full | w_rd_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // Set has priority over clear when both happen on one edge.
            if (wren && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end

            if (rden && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Storage is not reset; unoccupied entries are never observed.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry falls through; o_data is meaningless while empty.
    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = ~w_empty;
`else
    logic [DATA_WIDTH-1:0] r_o_data;
    logic                  r_o_valid;

    // o_data keeps the last popped word until the next accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o_data  <= '0;
            r_o_valid <= 1'b0;
        end else begin
            r_o_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_o_data <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_data  = r_o_data;
    assign o_valid = r_o_valid;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= LP_AFULL);
    assign almost_empty = (r_count <= LP_AEMPTY);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_circ.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_circ
//
// Bench for sync_fifo_circ. The reference is a plain queue: occupancy is the
// queue size, flags are threshold compares on that size, reads pop the front.
// Each step drives one cycle of requests, advances one clock and compares
// every output about 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo_circ;

    localparam int DEPTH  = 8;
    localparam int DW     = 8;
    localparam int AFULL  = 6;
    localparam int AEMPTY = 2;

    logic          clk;
    logic          rst_n;
    logic          wren;
    logic [DW-1:0] i_data;
    logic          rden;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;
    logic          clr_err;

    sync_fifo_circ #(
        .DEPTH        (DEPTH),
        .DATA_WIDTH   (DW),
        .AFULL_THRESH (AFULL),
        .AEMPTY_THRESH(AEMPTY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wren        (wren),
        .i_data      (i_data),
        .rden        (rden),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic          m_ovf;
    logic          m_unf;
    logic [DW-1:0] m_last;   // last popped word (registered-read mode)
    logic          m_valid;  // a pop happened on the last edge

    int total;
    int bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, ":count"},        32'(count),        32'(n));
        chk({tag, ":empty"},        32'(empty),        32'(n == 0));
        chk({tag, ":full"},         32'(full),         32'(n == DEPTH));
        chk({tag, ":almost_full"},  32'(almost_full),  32'(n >= AFULL));
        chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(n <= AEMPTY));
        chk({tag, ":overflow"},     32'(overflow),     32'(m_ovf));
        chk({tag, ":underflow"},    32'(underflow),    32'(m_unf));
`ifdef FIFO_FWFT_EN
        chk({tag, ":o_valid"}, 32'(o_valid), 32'(n != 0));
        if (n != 0) chk({tag, ":o_data"}, 32'(o_data), 32'(exp_q[0]));
`else
        chk({tag, ":o_valid"}, 32'(o_valid), 32'(m_valid));
        chk({tag, ":o_data"},  32'(o_data),  32'(m_last));
`endif
    endtask

    // One clock: drive requests, update the model from pre-edge occupancy,
    // then compare after the edge.
    task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                        input logic r, input logic c);
        bit r_ok;
        bit w_ok;
        int n;
        wren    = w;
        i_data  = d;
        rden    = r;
        clr_err = c;
        n    = exp_q.size();
        r_ok = r && (n > 0);
        w_ok = w && ((n < DEPTH) || r_ok);
        m_valid = r_ok;
        if (r_ok) m_last = exp_q.pop_front();
        if (w_ok) exp_q.push_back(d);
        if (w && !w_ok)     m_ovf = 1'b1;
        else if (c)         m_ovf = 1'b0;
        if (r && (n == 0))  m_unf = 1'b1;
        else if (c)         m_unf = 1'b0;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_last  = '0;
        m_valid = 1'b0;
    endtask

    // Reset asserted between edges; effects must be visible without a clock.
    task automatic async_reset(input string tag);
        #2;
        rst_n   = 1'b0;
        wren    = 1'b0;
        rden    = 1'b0;
        clr_err = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the sequence below is clock-driven, this only guards a hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        wren    = 1'b0;
        rden    = 1'b0;
        clr_err = 1'b0;
        i_data  = '0;
        model_reset();

        // 1. reset then idle
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle("idle0");
        idle("idle1");

        // 2. fill 0x11..0x88, then drain in order
        for (int i = 1; i <= 8; i++) step("fill", 1'b1, DW'(i * 8'h11), 1'b0, 1'b0);
        chk("fill:full_after_8", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
        idle("drain_idle");

        // 3. overflow at full, then concurrent read+write at full
        for (int i = 1; i <= 8; i++) step("refill", 1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
        step("ovf_write", 1'b1, 8'h99, 1'b0, 1'b0);
        chk("ovf:set", 32'(overflow), 32'd1);
        chk("ovf:count8", 32'(count), 32'd8);
        step("full_rw", 1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_rw:count8", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) step("drain2", 1'b0, '0, 1'b1, 1'b0);
        chk("drain2:last_is_aa", 32'(o_data), 32'h00AA_0000 >> 16);
        step("clr_ovf", 1'b0, '0, 1'b0, 1'b1);

        // 4. wrap-around with occupancy held near 3
        for (int i = 0; i < 3; i++) step("wrap_pre", 1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            step("wrap", 1'b1, DW'($urandom_range(0, 255)), exp_q.size() >= 3, 1'b0);
            chk("wrap:count_le4", 32'(count <= 4'd4), 32'd1);
        end
        while (exp_q.size() > 0) step("wrap_drain", 1'b0, '0, 1'b1, 1'b0);

        // 5. underflow, simultaneous rw on empty, clear
        step("unf_read", 1'b0, '0, 1'b1, 1'b0);
        chk("unf:set", 32'(underflow), 32'd1);
        step("unf_rw", 1'b1, 8'h3C, 1'b1, 1'b0);
        chk("unf_rw:count1", 32'(count), 32'd1);
        step("unf_clr", 1'b0, '0, 1'b0, 1'b1);
        chk("unf:cleared", 32'(underflow), 32'd0);
        step("unf_pop", 1'b0, '0, 1'b1, 1'b0);
        step("clr_vs_set", 1'b0, '0, 1'b1, 1'b1);

        // 6. first-word visibility and reset mid-operation
        step("fwft_wr", 1'b1, 8'h5A, 1'b0, 1'b1);
        idle("fwft_hold");
        for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
        chk("pre_rst:count5", 32'(count), 32'd5);
        async_reset("mid_rst");
        idle("post_rst");
        step("post_rst_wr", 1'b1, 8'hE1, 1'b0, 1'b0);
        step("post_rst_rd", 1'b0, '0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_circ.md
Name: sync_fifo_circ

Overview:
Parametrised single-clock circular-buffer FIFO replacing the shift-register FIFO in the datapath.
- Read/write pointers instead of shifting storage.
- Concurrent read and write at any occupancy, including full and empty.
- Occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags.
- Sits between producer and consumer stages (e.g. MAC input staging). Read-output timing is selectable at compile time.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2
DATA_WIDTH, 8, entry width in bits
AFULL_THRESH, 6, almost_full asserted when count >= AFULL_THRESH; range 1..DEPTH
AEMPTY_THRESH, 2, almost_empty asserted when count <= AEMPTY_THRESH; range 0..DEPTH-1

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
wren  in  1  write request
i_data  in  DATA_WIDTH  write data, sampled when write accepted
rden  in  1  read request / pop
o_data  out  DATA_WIDTH  read data
o_valid  out  1  o_data holds a popped (or head) entry
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_THRESH
almost_empty  out  1  count <= AEMPTY_THRESH
count  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
overflow  out  1  sticky: write attempted and rejected
underflow  out  1  sticky: read attempted on empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr=rd_ptr=0, count=0, o_data=0, o_valid=0, overflow=underflow=0.
  - Storage contents are don't-care and need not be reset.
  - Flags after reset: empty=1, full=0, almost_empty=1, almost_full=(AFULL_THRESH==0? n/a)=0.
- Accept rules, evaluated on pre-edge state:
  - rd_acc = rden & !empty.
  - wr_acc = wren & (!full | rd_acc). A write at full is accepted only when a read is accepted in the same cycle.
- Pointers are $clog2(DEPTH) bits.
  - wr_acc: mem[wr_ptr]<=i_data; wr_ptr<=wr_ptr+1, wraps DEPTH-1 -> 0 by natural overflow.
  - rd_acc: rd_ptr<=rd_ptr+1, same wrap.
- count update:
  - +1 when wr_acc & !rd_acc.
  - -1 when rd_acc & !wr_acc.
  - Unchanged otherwise, including simultaneous accept.
- full/empty/almost_* are combinational decodes of registered count. They change the cycle after the accepting edge; no lookahead.
- Simultaneous read+write on empty: write accepted, read rejected, underflow set. The new entry is not bypassed to the output.
- Ordering: strict FIFO. The entry written N-th is the entry read N-th.
- Error flags:
  - overflow<=1 when wren & !wr_acc.
  - underflow<=1 when rden & empty.
  - Both hold until clr_err=1 for one cycle. If set and clear occur in the same cycle, set wins.
- Rejected operations change no pointer, count or storage.
- Reset mid-operation: all state returns to reset values immediately, regardless of outstanding requests. The first accepted write after rst_n deasserts goes to entry 0.
- Default read timing (no macro):
  - o_data is registered; it loads mem[rd_ptr] on rd_acc.
  - o_valid=1 exactly the cycle after rd_acc, otherwise 0.
  - o_data holds its last value when no read is accepted.

Optional Feature:
Macro FIFO_FWFT_EN selects first-word-fall-through mode.
- Defined:
  - o_data = mem[rd_ptr] combinationally; o_valid = !empty.
  - rden acts as acknowledge: on rd_acc the head advances, so the next entry appears after the edge.
  - A word written into an empty FIFO is visible on o_data the cycle after the write edge.
  - o_data is don't-care while empty.
- Undefined: default registered one-cycle read latency as described in Behaviour.
- Accept rules, count, flags and error flags are identical in both modes.

Test Plan:
1. Reset then idle → empty=1, full=0, count=0, almost_empty=1, o_valid=0, overflow=underflow=0.
2. Fill ordering: write 0x11..0x88 on 8 consecutive cycles, then read 8 (default mode) → o_valid 1 cycle after each rden; o_data 0x11..0x88 in order; full=1 and almost_full=1 after the 8th write; count steps 8→0.
3. Overflow and full-cycle concurrency:
   - Write 0x99 while full, rden=0 → rejected, overflow=1, count stays 8.
   - Then wren=rden=1 with 0xAA → both accepted, count stays 8, 0xAA is read last.
4. Wrap-around: run 20 writes interleaved with reads at count ≈3 → data order preserved across pointer wrap; count never exceeds 4.
5. Underflow and clear:
   - rden=1 on empty → underflow=1, o_valid stays 0.
   - Simultaneous wren=rden=1 on empty → count=1, underflow remains 1.
   - clr_err pulse → underflow=0.
6. FWFT and reset mid-operation:
   - With FIFO_FWFT_EN: write 0x5A to empty → o_valid=1, o_data=0x5A next cycle, before any rden.
   - Assert rst_n=0 at count=5 → count=0 and empty=1 immediately.
